// File: rtl/branch_outcome_tracker.sv
// branch_outcome_tracker: in-order prediction queue that trains the predictor and flushes on mispredict; optional counters under BOT_STATS_EN
module branch_outcome_tracker #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pred_valid,
  input  logic             pred_taken,
  output logic             pred_ready,
  input  logic             resolve_valid,
  input  logic             resolve_taken,
  output logic             upd_valid,
  output logic             upd_taken,
  output logic             mispredict,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             err_overflow,
  output logic             err_underflow
`ifdef BOT_STATS_EN
  ,
  output logic [CNT_W-1:0] stat_resolved,
  output logic [CNT_W-1:0] stat_mispred
`endif
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  logic [DEPTH-1:0] q;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic push, pop, mis;
  assign empty      = count == '0;
  assign full       = count == FULL_CNT;
  assign pred_ready = !full;
  assign push       = pred_valid && !full;
  assign pop        = resolve_valid && !empty;
  assign mis        = pop && (q[rd_ptr] != resolve_taken);
  always_ff @(posedge clk)
    if (push) q[wr_ptr] <= pred_taken;
  // a mispredict squashes every younger entry, including a same-edge push
  always_ff @(posedge clk)
    if (rst) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      upd_valid     <= 1'b0;
      upd_taken     <= 1'b0;
      mispredict    <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      upd_valid     <= pop;
      upd_taken     <= pop && resolve_taken;
      mispredict    <= mis;
      err_overflow  <= err_overflow || (pred_valid && full);
      err_underflow <= err_underflow || (resolve_valid && empty);
      if (mis) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
        rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
        count  <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      end
    end
`ifdef BOT_STATS_EN
  always_ff @(posedge clk)
    if (rst) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
    end else begin
      stat_resolved <= (pop && !(&stat_resolved)) ? stat_resolved + 1'b1 : stat_resolved;
      stat_mispred  <= (mis && !(&stat_mispred)) ? stat_mispred + 1'b1 : stat_mispred;
    end
`endif
endmodule

// File: tb/tb_branch_outcome_tracker.sv
// tb_branch_outcome_tracker: scoreboard bench; expected update pulses queued at stimulus, compared against observed pulses
module tb_branch_outcome_tracker;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b0;
  logic pv = 1'b0, pt = 1'b0, rv = 1'b0, rt = 1'b0;
  logic pred_ready, upd_valid, upd_taken, mispredict, empty, full, err_overflow, err_underflow;
  logic [2:0] count;
`ifdef BOT_STATS_EN
  logic [1:0] stat_resolved, stat_mispred;
`endif
  logic [2:0] obs[$];
  logic [2:0] exp_q[$];
  bit mq[$];
  bit mov = 0, mund = 0;
  int ob = 0, rs = 0, ms = 0, n_cmp = 0, n_bad = 0;

  branch_outcome_tracker #(.DEPTH(DEPTH), .PTR_W(2), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .pred_valid(pv), .pred_taken(pt), .pred_ready(pred_ready),
    .resolve_valid(rv), .resolve_taken(rt), .upd_valid(upd_valid), .upd_taken(upd_taken),
    .mispredict(mispredict), .count(count), .empty(empty), .full(full),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
`ifdef BOT_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (upd_valid || upd_taken || mispredict) obs.push_back({upd_valid, upd_taken, mispredict});

  task cyc;
    @(posedge clk);
    #1;
  endtask

  task drive(input bit a, input bit b, input bit c, input bit d);
    bit p, r, m;
    r = c && mq.size() > 0;
    m = r && mq[0] != d;
    p = a && mq.size() < DEPTH;
    if (a && mq.size() == DEPTH) mov = 1;
    if (c && mq.size() == 0) mund = 1;
    if (r) begin
      exp_q.push_back({1'b1, d, m});
      if (rs < 3) rs++;
      if (m && ms < 3) ms++;
    end
    if (m) mq.delete();
    else begin
      if (r) void'(mq.pop_front());
      if (p) mq.push_back(b);
    end
    pv = a; pt = b; rv = c; rt = d;
    cyc;
    pv = 0; rv = 0;
  endtask

  task do_reset;
    rst = 1;
    cyc;
    rst = 0;
    mq.delete();
    mov = 0; mund = 0; rs = 0; ms = 0;
  endtask

  task test_reset;
    do_reset;
    n_cmp++;
    if ({count, empty, full, pred_ready} !== {3'd0, 3'b101}) begin
      n_bad++; $display("FAIL reset_occ got count=%0d e/f/r=%b%b%b want 0 101", count, empty, full, pred_ready);
    end
    n_cmp++;
    if ({upd_valid, upd_taken, mispredict, err_overflow, err_underflow} !== 5'b0) begin
      n_bad++; $display("FAIL reset_out got %b want 00000", {upd_valid, upd_taken, mispredict, err_overflow, err_underflow});
    end
  endtask

  task test_in_order;
    drive(1, 1, 0, 0); drive(1, 1, 0, 0); drive(1, 0, 0, 0);
    n_cmp++;
    if ({count, empty, full} !== {3'd3, 2'b00}) begin
      n_bad++; $display("FAIL inorder_occ got count=%0d e/f=%b%b want 3 00", count, empty, full);
    end
    drive(0, 0, 1, 1); drive(0, 0, 1, 1); drive(0, 0, 1, 0);
    cyc; cyc;
    n_cmp++;
    if (obs.size() - ob !== exp_q.size()) begin
      n_bad++; $display("FAIL inorder_pulses got %0d want %0d", obs.size() - ob, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && ob + i < obs.size(); i++) begin
      n_cmp++;
      if (obs[ob+i] !== exp_q[i]) begin
        n_bad++; $display("FAIL inorder_upd[%0d] got %b want %b", i, obs[ob+i], exp_q[i]);
      end
    end
    ob = obs.size(); exp_q.delete();
  endtask

  task test_full;
    for (int i = 0; i < DEPTH; i++) drive(1, i[0], 0, 0);
    n_cmp++;
    if ({full, pred_ready, count} !== {2'b10, 3'd4}) begin
      n_bad++; $display("FAIL full_flag got f/r=%b%b count=%0d want 10 4", full, pred_ready, count);
    end
    drive(1, 1, 0, 0);
    n_cmp++;
    if ({count, err_overflow} !== {3'd4, mov}) begin
      n_bad++; $display("FAIL overflow got count=%0d ov=%b want 4 %b", count, err_overflow, mov);
    end
    drive(1, 1, 1, 0);
    n_cmp++;
    if (count !== 3'(mq.size())) begin
      n_bad++; $display("FAIL full_push_pop got count=%0d want %0d", count, mq.size());
    end
    for (int i = 1; i < DEPTH; i++) drive(0, 0, 1, i[0]);
    cyc; cyc;
    n_cmp++;
    if ({empty, count} !== {1'b1, 3'd0}) begin
      n_bad++; $display("FAIL full_drain got e=%b count=%0d want 1 0", empty, count);
    end
    n_cmp++;
    if (obs.size() - ob !== exp_q.size()) begin
      n_bad++; $display("FAIL full_pulses got %0d want %0d", obs.size() - ob, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && ob + i < obs.size(); i++) begin
      n_cmp++;
      if (obs[ob+i] !== exp_q[i]) begin
        n_bad++; $display("FAIL full_upd[%0d] got %b want %b", i, obs[ob+i], exp_q[i]);
      end
    end
    ob = obs.size(); exp_q.delete();
  endtask

  task test_mispredict;
    drive(1, 1, 0, 0); drive(1, 0, 0, 0); drive(1, 0, 0, 0);
    drive(0, 0, 1, 0);
    n_cmp++;
    if ({upd_valid, upd_taken, mispredict, count} !== {3'b101, 3'd0}) begin
      n_bad++; $display("FAIL mispred_pulse got uv/ut/mp=%b%b%b count=%0d want 101 0", upd_valid, upd_taken, mispredict, count);
    end
    cyc;
    n_cmp++;
    if ({mispredict, upd_valid, empty} !== 3'b001) begin
      n_bad++; $display("FAIL mispred_once got mp/uv/e=%b%b%b want 001", mispredict, upd_valid, empty);
    end
    ob = obs.size(); exp_q.delete();
  endtask

  task test_back_to_back;
    drive(1, 1, 0, 0); drive(1, 0, 0, 0);
    drive(1, 1, 1, 1);
    n_cmp++;
    if (count !== 3'd2) begin
      n_bad++; $display("FAIL b2b_correct got count=%0d want 2", count);
    end
    drive(1, 1, 1, 1);
    n_cmp++;
    if ({count, mispredict} !== {3'd0, 1'b1}) begin
      n_bad++; $display("FAIL b2b_mispred got count=%0d mp=%b want 0 1", count, mispredict);
    end
    cyc; cyc;
    n_cmp++;
    if (obs.size() - ob !== exp_q.size()) begin
      n_bad++; $display("FAIL b2b_pulses got %0d want %0d", obs.size() - ob, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && ob + i < obs.size(); i++) begin
      n_cmp++;
      if (obs[ob+i] !== exp_q[i]) begin
        n_bad++; $display("FAIL b2b_upd[%0d] got %b want %b", i, obs[ob+i], exp_q[i]);
      end
    end
    ob = obs.size(); exp_q.delete();
  endtask

  task test_underflow;
    drive(0, 0, 1, 1);
    cyc;
    n_cmp++;
    if ({err_underflow, 3'(obs.size() - ob)} !== {mund, 3'd0}) begin
      n_bad++; $display("FAIL underflow got un=%b pulses=%0d want %b 0", err_underflow, obs.size() - ob, mund);
    end
    drive(1, 1, 0, 0); drive(1, 0, 0, 0); drive(1, 1, 0, 0);
    pv = 1; rv = 1; rt = 1;
    do_reset;
    pv = 0; rv = 0;
    cyc;
    n_cmp++;
    if ({count, err_underflow, err_overflow, 3'(obs.size() - ob)} !== {3'd0, 2'b00, 3'd0}) begin
      n_bad++; $display("FAIL mid_reset got count=%0d un/ov=%b%b pulses=%0d want 0 00 0", count, err_underflow, err_overflow, obs.size() - ob);
    end
    ob = obs.size(); exp_q.delete();
  endtask

`ifdef BOT_STATS_EN
  task test_stats;
    do_reset;
    n_cmp++;
    if ({stat_resolved, stat_mispred} !== 4'b0) begin
      n_bad++; $display("FAIL stats_reset got %0d/%0d want 0/0", stat_resolved, stat_mispred);
    end
    drive(1, 1, 0, 0); drive(0, 0, 1, 1);
    drive(1, 1, 0, 0); drive(0, 0, 1, 0);
    drive(1, 0, 0, 0); drive(0, 0, 1, 0);
    drive(1, 0, 0, 0); drive(0, 0, 1, 1);
    drive(1, 1, 0, 0); drive(0, 0, 1, 1);
    n_cmp++;
    if ({stat_resolved, stat_mispred} !== {2'(rs), 2'(ms)}) begin
      n_bad++; $display("FAIL stats got %0d/%0d want %0d/%0d", stat_resolved, stat_mispred, rs, ms);
    end
    cyc; cyc;
    ob = obs.size(); exp_q.delete();
  endtask
`endif

  initial begin
    test_reset;
    test_in_order;
    test_full;
    test_mispredict;
    test_back_to_back;
    test_underflow;
`ifdef BOT_STATS_EN
    test_stats;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
